// File: rtl/lora_cmd_tx_if.sv
// Command-link handshake between the remote's button logic and the LoRa UART framer.
interface lora_cmd_tx_if;
    logic       send;
    logic [7:0] cmd;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] seq;

    modport master (
        output send, cmd,
        input  tx, busy, done, seq
    );

    modport slave (
        input  send, cmd,
        output tx, busy, done, seq
    );
endinterface

// File: rtl/lora_cmd_tx.sv
// Frames a command byte as A5/cmd/seq/xor-checksum and shifts it out as 8N1 UART,
// with optional idle bit-times after each byte.
module lora_cmd_tx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned GAP_BITS = 0
) (
    input logic          clk,
    input logic          rst,
    lora_cmd_tx_if.slave bus
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned BaudW      = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned GapW       = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam int unsigned GapLastInt = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(GapLastInt);
    localparam logic [7:0]       SyncByte = 8'hA5;

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StGap} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [7:0]        cmd_q, frm_seq_q, seq_q;
    logic              done_q;

    logic              bit_tick;
    logic              byte_done;
    logic              load;
    logic              frame_end;
    logic [7:0]        cur_byte;
    logic              tx_c;
    logic              busy_c;

    assign bit_tick = (baud_q == BaudLast);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, frame buffer and end-of-frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            gap_q     <= '0;
            cmd_q     <= '0;
            frm_seq_q <= '0;
            seq_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            baud_q <= baud_d;
            bit_q  <= bit_d;
            byte_q <= byte_d;
            gap_q  <= gap_d;
            done_q <= frame_end;
            if (load) begin
                cmd_q     <= bus.cmd;
                frm_seq_q <= seq_q;
            end
            if (frame_end) begin
                seq_q <= seq_q + 8'd1;
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        gap_d     = gap_q;
        load      = 1'b0;
        frame_end = 1'b0;
        byte_done = 1'b0;
        baud_d    = (state_q == StIdle || bit_tick) ? '0 : baud_q + BaudW'(1);

        case (state_q)
            StIdle: begin
                if (bus.send) begin
                    state_d = StStart;
                    byte_d  = '0;
                    load    = 1'b1;
                end
            end
            StStart: begin
                if (bit_tick) state_d = StData;
            end
            StData: begin
                if (bit_tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_tick) begin
                    if (GAP_BITS != 0) state_d = StGap;
                    else               byte_done = 1'b1;
                end
            end
            StGap: begin
                if (bit_tick) begin
                    if (gap_q == GapLast) begin
                        gap_d     = '0;
                        byte_done = 1'b1;
                    end else begin
                        gap_d = gap_q + GapW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (byte_done) begin
            if (byte_q == 2'd3) begin
                state_d   = StIdle;
                byte_d    = '0;
                frame_end = 1'b1;
            end else begin
                state_d = StStart;
                byte_d  = byte_q + 2'd1;
            end
        end
    end

    // Byte selection uses the latched cmd/seq so input changes mid-frame cannot leak in
    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = SyncByte;
            2'd1:    cur_byte = cmd_q;
            2'd2:    cur_byte = frm_seq_q;
            default: cur_byte = SyncByte ^ cmd_q ^ frm_seq_q;
        endcase
    end

    // Output logic
    always_comb begin
        busy_c = (state_q != StIdle);
        case (state_q)
            StStart: tx_c = 1'b0;
            StData:  tx_c = cur_byte[bit_q];
            default: tx_c = 1'b1;
        endcase
    end

    assign bus.tx   = tx_c;
    assign bus.busy = busy_c;
    assign bus.done = done_q;
    assign bus.seq  = seq_q;

endmodule
